// File: rtl/hex_entry_pkg.sv
// hex_entry_pkg: shared constants and debounce state type for the front-panel digit reader
package hex_entry_pkg;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam int         NUM_DIGITS = 4;
    localparam int         KEY_ENTER  = 0;
    localparam int         KEY_CLEAR  = 1;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } deb_state_t;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes an active-low key and emits one press pulse per stable press
module key_debounce
    import hex_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic press_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    deb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          key_s, done;

    assign key_s = sync_q[1];
    assign done  = cnt_q == CNT_LAST;

    // Two-flop synchronizer, debounce state and counter; reset leaves the key released
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_ni};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter runs only while waiting out a change and is cleared on every transition
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        press_o = 1'b0;
        case (state_q)
            RELEASED:     if (!key_s) state_d = PRESS_WAIT;
            PRESS_WAIT: begin
                if (key_s) state_d = RELEASED;
                else if (done) begin
                    state_d = PRESSED;
                    press_o = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            end
            PRESSED:      if (key_s) state_d = RELEASE_WAIT;
            RELEASE_WAIT: begin
                if (!key_s) state_d = PRESSED;
                else if (done) state_d = RELEASED;
                else cnt_d = cnt_q + 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/hex_digit_entry.sv
// hex_digit_entry: debounced enter/clear keys build a four-digit BCD number from switch entries
module hex_digit_entry
    import hex_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                    CLOCK_50,
    input  logic                    RST_N,
    input  logic [1:0]              KEY,
    input  logic [3:0]              SW,
    output logic [4*NUM_DIGITS-1:0] DIGITS,
    output logic [NUM_DIGITS-1:0]   VALID,
    output logic                    ERR,
    output logic                    ENTER_PULSE
);
    logic                    enter_ev, clear_ev, sw_ok, take;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    err_q, err_d, pulse_q;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk_i  (CLOCK_50),
        .rst_ni (RST_N),
        .key_ni (KEY[KEY_ENTER]),
        .press_o(enter_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk_i  (CLOCK_50),
        .rst_ni (RST_N),
        .key_ni (KEY[KEY_CLEAR]),
        .press_o(clear_ev)
    );

    // Clear overrides enter; only an in-range switch value is shifted in
    always_comb begin
        sw_ok    = SW <= BCD_MAX;
        take     = enter_ev && !clear_ev && sw_ok;
        digits_d = clear_ev ? '0 : take ? {digits_q[4*NUM_DIGITS-5:0], SW} : digits_q;
        valid_d  = clear_ev ? '0 : take ? {valid_q[NUM_DIGITS-2:0], 1'b1} : valid_q;
        err_d    = clear_ev ? 1'b0 : enter_ev ? !sw_ok : err_q;
    end

    // Registered outputs, so nothing from KEY or SW reaches them combinationally
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            digits_q <= '0;
            valid_q  <= '0;
            err_q    <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            digits_q <= digits_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            pulse_q  <= take;
        end
    end

    assign DIGITS      = digits_q;
    assign VALID       = valid_q;
    assign ERR         = err_q;
    assign ENTER_PULSE = pulse_q;
endmodule

// File: tb/tb_hex_digit_entry.sv
// tb_hex_digit_entry: directed table and corner-case sequences for hex_digit_entry
module tb_hex_digit_entry;
    logic        CLOCK_50 = 1'b0;
    logic        RST_N;
    logic [1:0]  KEY;
    logic [3:0]  SW;
    logic [15:0] DIGITS;
    logic [3:0]  VALID;
    logic        ERR;
    logic        ENTER_PULSE;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0]  sw;
        logic [15:0] digits;
        logic [3:0]  valid;
        logic        err;
        int          pulse_at;
    } vec_t;

    vec_t vecs [7];

    hex_digit_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50   (CLOCK_50),
        .RST_N      (RST_N),
        .KEY        (KEY),
        .SW         (SW),
        .DIGITS     (DIGITS),
        .VALID      (VALID),
        .ERR        (ERR),
        .ENTER_PULSE(ENTER_PULSE)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic run_window(input int n, output int first, output int cnt);
        first = 0;
        cnt   = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (ENTER_PULSE) begin
                cnt++;
                if (first == 0) first = k;
            end
        end
    endtask

    task automatic press(input logic [1:0] keys, input logic [3:0] sw, input int hold,
                         output int first, output int cnt);
        int f2, c2;
        SW  = sw;
        KEY = keys;
        run_window(hold, first, cnt);
        KEY = 2'b11;
        run_window(10, f2, c2);
        cnt += c2;
    endtask

    initial begin
        int first, cnt;
        logic [9:0] pat;
        vecs[0] = '{4'd6, 16'h0006, 4'b0001, 1'b0, 7};
        vecs[1] = '{4'd2, 16'h0062, 4'b0011, 1'b0, 7};
        vecs[2] = '{4'd5, 16'h0625, 4'b0111, 1'b0, 7};
        vecs[3] = '{4'd6, 16'h6256, 4'b1111, 1'b0, 7};
        vecs[4] = '{4'd1, 16'h2561, 4'b1111, 1'b0, 7};
        vecs[5] = '{4'hC, 16'h2561, 4'b1111, 1'b1, 0};
        vecs[6] = '{4'd3, 16'h5613, 4'b1111, 1'b0, 7};

        RST_N = 1'b0;
        KEY   = 2'b11;
        SW    = 4'd0;
        repeat (3) tick();
        check("reset_digits", 32'(DIGITS), 32'h0);
        check("reset_valid", 32'(VALID), 32'h0);
        check("reset_err", 32'(ERR), 32'h0);
        check("reset_pulse", 32'(ENTER_PULSE), 32'h0);
        RST_N = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 7; i++) begin
            press(2'b10, vecs[i].sw, 10, first, cnt);
            check($sformatf("v%0d_digits", i), 32'(DIGITS), 32'(vecs[i].digits));
            check($sformatf("v%0d_valid", i), 32'(VALID), 32'(vecs[i].valid));
            check($sformatf("v%0d_err", i), 32'(ERR), 32'(vecs[i].err));
            check($sformatf("v%0d_pulse_at", i), 32'(first), 32'(vecs[i].pulse_at));
            check($sformatf("v%0d_pulse_cnt", i), 32'(cnt), (vecs[i].pulse_at != 0) ? 32'd1 : 32'd0);
        end

        // Bounce: final low run first seen at edge 6, event strobe at edge 12
        pat = 10'b0000010010;
        SW  = 4'd7;
        first = 0;
        cnt   = 0;
        for (int j = 1; j <= 20; j++) begin
            KEY[0] = (j <= 10) ? pat[j-1] : 1'b0;
            tick();
            if (ENTER_PULSE) begin
                cnt++;
                if (first == 0) first = j;
            end
        end
        KEY = 2'b11;
        repeat (10) tick();
        check("bounce_cnt", 32'(cnt), 32'd1);
        check("bounce_at", 32'(first), 32'd12);
        check("bounce_digits", 32'(DIGITS), 32'h6137);

        // Three-cycle glitch must be ignored
        KEY[0] = 1'b0;
        run_window(3, first, cnt);
        KEY[0] = 1'b1;
        begin
            int f2, c2;
            run_window(12, f2, c2);
            cnt += c2;
        end
        check("glitch_cnt", 32'(cnt), 32'd0);
        check("glitch_digits", 32'(DIGITS), 32'h6137);

        // Long hold gives exactly one shift
        press(2'b10, 4'd8, 50, first, cnt);
        check("hold_cnt", 32'(cnt), 32'd1);
        check("hold_digits", 32'(DIGITS), 32'h1378);

        // Set ERR, then simultaneous enter and clear: clear wins
        press(2'b10, 4'hD, 10, first, cnt);
        check("err_set", 32'(ERR), 32'h1);
        press(2'b00, 4'd9, 10, first, cnt);
        check("both_digits", 32'(DIGITS), 32'h0);
        check("both_valid", 32'(VALID), 32'h0);
        check("both_err", 32'(ERR), 32'h0);
        check("both_pulse", 32'(cnt), 32'd0);

        // Reset during PRESS_WAIT with key held through release
        press(2'b10, 4'd5, 10, first, cnt);
        check("pre_rst_digits", 32'(DIGITS), 32'h0005);
        SW     = 4'd4;
        KEY[0] = 1'b0;
        repeat (4) tick();
        RST_N = 1'b0;
        repeat (2) tick();
        check("mid_rst_digits", 32'(DIGITS), 32'h0);
        check("mid_rst_valid", 32'(VALID), 32'h0);
        check("mid_rst_pulse", 32'(ENTER_PULSE), 32'h0);
        RST_N = 1'b1;
        run_window(12, first, cnt);
        KEY = 2'b11;
        repeat (10) tick();
        check("post_rst_at", 32'(first), 32'd7);
        check("post_rst_cnt", 32'(cnt), 32'd1);
        check("post_rst_digits", 32'(DIGITS), 32'h0004);
        check("post_rst_valid", 32'(VALID), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hex_digit_entry.md
# hex_digit_entry

Front-panel input reader for the board's four-digit decimal display. It debounces two push-buttons and assembles a four-digit BCD number from switch entries. It is the input side of the HEX display path: its BCD digits and per-digit valid flags feed the existing per-digit `dec_to_hex` segment decoders, and blank digits show as unlit.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before a key change is accepted (20 ms at 50 MHz).

Ports:
- `CLOCK_50`, in, 1: sole clock; all state is on the rising edge.
- `RST_N`, in, 1: reset, synchronous, active-low.
- `KEY`, in, 2: raw push-buttons, active-low, asynchronous to `CLOCK_50`.
  - `KEY[0]` = enter.
  - `KEY[1]` = clear.
- `SW`, in, 4: digit value to enter, binary 0–15, level-sampled.
- `DIGITS`, out, 16: four BCD digits; `[3:0]` is the rightmost (HEX0), `[15:12]` is the leftmost (HEX3).
- `VALID`, out, 4: per-digit valid flag; `VALID[i]` qualifies `DIGITS[4i+3:4i]`.
- `ERR`, out, 1: last enter attempt had `SW` > 9 (drives an LEDR).
- `ENTER_PULSE`, out, 1: one-cycle strobe on each accepted digit.

## Operation
- Each `KEY` bit passes through a 2-flop synchronizer. The synchronizer flops reset to 1 (released).
- Per-key debounce FSM has four states:
  - `RELEASED`: sync input 0 → `PRESS_WAIT`, counter cleared.
  - `PRESS_WAIT`: counter increments while input is 0. Input returns to 1 → `RELEASED`. Counter reaches `DEBOUNCE_CYCLES`-1 → `PRESSED` and emits a one-cycle press event.
  - `PRESSED`: sync input 1 → `RELEASE_WAIT`, counter cleared.
  - `RELEASE_WAIT`: mirror of `PRESS_WAIT`. Input back to 0 → `PRESSED`. Count completes → `RELEASED`. No event is emitted on release.
- Counter width is clog2(`DEBOUNCE_CYCLES`). The counter never wraps: it is cleared on every state change.
- Holding a key produces exactly one event. There is no auto-repeat.
- Enter event with `SW` ≤ 9:
  - `DIGITS` ← {`DIGITS[11:0]`, `SW`}.
  - `VALID` ← {`VALID[2:0]`, 1}.
  - `ERR` ← 0.
  - `ENTER_PULSE` = 1.
- Enter event with `SW` ≥ 10 (10–15):
  - `DIGITS` and `VALID` are unchanged.
  - `ERR` ← 1.
  - `ENTER_PULSE` stays 0.
- Full register (`VALID` = 4'b1111): a valid enter still shifts. The leftmost digit is discarded and `VALID` stays 4'b1111.
- Clear event: `DIGITS` ← 0, `VALID` ← 0, `ERR` ← 0.
- Clear and enter events in the same cycle: clear wins and the enter is dropped.
- `ERR` is sticky. Only a valid enter, a clear, or reset lowers it.
- `SW` is sampled only in the cycle of the enter event. Changes to `SW` at any other time have no effect.

## Timing
- Reset values (`RST_N` low at a clock edge):
  - `DIGITS` = 0, `VALID` = 0, `ERR` = 0, `ENTER_PULSE` = 0.
  - Both FSMs in `RELEASED`, counters 0, synchronizer flops 1.
- Reset asserted mid-debounce or mid-press aborts the sequence. A key still held after reset release must pass a full `DEBOUNCE_CYCLES` window before registering a press.
- Latency, with `KEY[0]` going low before edge N and held low:
  - Press event is internal in the cycle after edge N+1+`DEBOUNCE_CYCLES`.
  - `DIGITS`, `VALID` and `ERR` update, and `ENTER_PULSE` goes high, at edge N+2+`DEBOUNCE_CYCLES`.
  - `ENTER_PULSE` stays high for exactly one cycle.
- Glitches: any low pulse shorter than `DEBOUNCE_CYCLES` cycles at the synchronizer output produces no event.
- Back-to-back events on the same key are at least 2·`DEBOUNCE_CYCLES` cycles apart.
- Outputs are registered, with no combinational path from `KEY` or `SW`.

## Structure
- Package `hex_entry_pkg` holds:
  - `BCD_MAX` = 4'd9.
  - `NUM_DIGITS` = 4.
  - Key index constants `KEY_ENTER` = 0 and `KEY_CLEAR` = 1.
  - Enumerated debounce state type `deb_state_t` {`RELEASED`, `PRESS_WAIT`, `PRESSED`, `RELEASE_WAIT`}.
- Sub-module `key_debounce` contains the synchronizer, counter and FSM, and emits `press`. It takes the `DEBOUNCE_CYCLES` parameter and is instantiated twice.
- The top level `hex_digit_entry` holds the shift register, valid/err logic and the clear-priority mux.

## Test plan
Use `DEBOUNCE_CYCLES` = 4 in simulation.
- Reset, then enter with `SW` = 6, 2, 5, 6 (key held ≥ 6 cycles each) → `DIGITS` = 16'h6256, `VALID` = 4'b1111, four `ENTER_PULSE` strobes, each at edge N+6 relative to the key-low edge N.
- From 16'h6256 full, enter `SW` = 1 → `DIGITS` = 16'h2561, `VALID` = 4'b1111.
- Enter `SW` = 4'hC → `DIGITS` unchanged, `ERR` = 1, no `ENTER_PULSE`. Then enter `SW` = 3 → `ERR` = 0 and digit 3 is shifted in.
- `KEY[0]` bounce pattern 0,1,0,0,1,0,0,0,0,0 then held → exactly one event, occurring 4 stable cycles after the last bounce. A 3-cycle low glitch → no event.
- Hold `KEY[0]` for 50 cycles → exactly one shift. Press `KEY[0]` and `KEY[1]` simultaneously → `DIGITS` = 0, `VALID` = 0, `ERR` = 0.
- Assert `RST_N` low during `PRESS_WAIT` with the key still held through reset release → no event until 4 full stable cycles after release. All outputs read 0 during reset.
